// File: rtl/smbus_ioexp_int_sched_pkg.sv
// rtl/smbus_ioexp_int_sched_pkg.sv - shared types and defaults for the IO-expander interrupt scheduler
package ioexp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ASSERT = 3'd1,
    ST_DELAY  = 3'd2,
    ST_ACK    = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  localparam logic [15:0] HOLDOFF_MS_DEF = 16'd2250;
  localparam logic [15:0] TIMEOUT_MS_DEF = 16'd0;

  // ms counters stick at all-ones instead of wrapping back to zero
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/smbus_ioexp_int_sched_if.sv
// rtl/smbus_ioexp_int_sched_if.sv - request/read/ack bundle between expanders and the scheduler
interface smbus_ioexp_int_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 3
);
  logic [NUM_REQ-1:0] iReq;
  logic [NUM_REQ-1:0] iP0_rd;
  logic [NUM_REQ-1:0] iP1_rd;
  logic [NUM_REQ-1:0] oAck;
  logic [IDXW-1:0]    oGrant_idx;

  modport master (input iReq, iP0_rd, iP1_rd, output oAck, oGrant_idx);
  modport slave  (output iReq, iP0_rd, iP1_rd, input oAck, oGrant_idx);
endinterface

// File: rtl/smbus_ioexp_int_sched_rr_arbiter.sv
// rtl/smbus_ioexp_int_sched_rr_arbiter.sv - combinational round-robin search from a pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic               valid,
  output logic [IDXW-1:0]    idx
);

  int pos;

  // Walk offsets high to low so the smallest offset from ptr wins
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (|(req & (NUM_REQ'(1) << pos))) begin
        valid = 1'b1;
        idx   = IDXW'(pos);
      end
    end
  end

endmodule

// File: rtl/smbus_ioexp_int_sched.sv
// rtl/smbus_ioexp_int_sched.sv - round-robin shared INT_N scheduler for SMBus IO-expander instances
module smbus_ioexp_int_sched
  import ioexp_pkg::*;
#(
  parameter int          NUM_REQ    = 4,
  parameter int          IDXW       = 3,
  parameter logic [15:0] HOLDOFF_MS = HOLDOFF_MS_DEF,
  parameter logic [15:0] TIMEOUT_MS = TIMEOUT_MS_DEF
) (
  input  logic iClk,
  input  logic nrst,
  input  logic iClk_1ms,
  input  logic iEnable,
  input  logic iTimeout_clr,
  smbus_ioexp_int_sched_if.master bus,
  output logic oINT_N,
  output logic oBusy,
  output logic oTimeout_flag
);

  state_t             state, state_nxt;
  logic [IDXW-1:0]    grant_q, grant_nxt;
  logic [IDXW-1:0]    rr_ptr, ptr_nxt;
  logic               seen_p0, seen_p0_nxt;
  logic               seen_p1, seen_p1_nxt;
  logic [15:0]        cnt, cnt_nxt;
  logic               int_n_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               tmo_q, tmo_set;
  logic               arb_valid;
  logic [IDXW-1:0]    arb_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic               p0_hit, p1_hit, req_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_arb (
    .req   (bus.iReq),
    .ptr   (rr_ptr),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  assign grant_oh = NUM_REQ'(1) << grant_q;
  assign p0_hit   = |(bus.iP0_rd & grant_oh);
  assign p1_hit   = |(bus.iP1_rd & grant_oh);
  assign req_hit  = |(bus.iReq & grant_oh);

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_q;
    ptr_nxt     = rr_ptr;
    seen_p0_nxt = seen_p0;
    seen_p1_nxt = seen_p1;
    cnt_nxt     = cnt;
    tmo_set     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iEnable && arb_valid) begin
          grant_nxt   = arb_idx;
          seen_p0_nxt = 1'b0;
          seen_p1_nxt = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        // A withdrawn request or disable abandons the grant without acking
        if (!iEnable || !req_hit) begin
          state_nxt = ST_IDLE;
        end else if ((TIMEOUT_MS != 16'd0) && (cnt >= TIMEOUT_MS)) begin
          tmo_set   = 1'b1;
          state_nxt = ST_ACK;
        end else begin
          seen_p0_nxt = seen_p0 | p0_hit;
          seen_p1_nxt = seen_p1 | p1_hit;
          if (seen_p0_nxt && seen_p1_nxt) begin
            cnt_nxt   = '0;
            state_nxt = ST_DELAY;
          end else begin
            cnt_nxt = sat_inc(cnt, iClk_1ms);
          end
        end
      end
      ST_DELAY: begin
        if (!iEnable)                state_nxt = ST_IDLE;
        else if (cnt == HOLDOFF_MS)  state_nxt = ST_ACK;
        else                         cnt_nxt   = sat_inc(cnt, iClk_1ms);
      end
      ST_ACK: begin
        ptr_nxt   = (grant_q == IDXW'(NUM_REQ - 1)) ? '0 : grant_q + IDXW'(1);
        state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (iClk_1ms) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nrst) begin
    if (!nrst) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      rr_ptr  <= '0;
      seen_p0 <= 1'b0;
      seen_p1 <= 1'b0;
      cnt     <= '0;
      int_n_q <= 1'b1;
      ack_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      rr_ptr  <= ptr_nxt;
      seen_p0 <= seen_p0_nxt;
      seen_p1 <= seen_p1_nxt;
      cnt     <= cnt_nxt;
      int_n_q <= !((state_nxt == ST_ASSERT) || (state_nxt == ST_DELAY));
      ack_q   <= (state_nxt == ST_ACK) ? (NUM_REQ'(1) << grant_nxt) : '0;
      if (tmo_set)           tmo_q <= 1'b1;
      else if (iTimeout_clr) tmo_q <= 1'b0;
    end
  end

  assign oINT_N         = int_n_q;
  assign oBusy          = (state != ST_IDLE);
  assign oTimeout_flag  = tmo_q;
  assign bus.oAck       = ack_q;
  assign bus.oGrant_idx = grant_q;

endmodule

// File: tb/tb_smbus_ioexp_int_sched.sv
// tb/tb_smbus_ioexp_int_sched.sv - scoreboard bench for the IO-expander interrupt scheduler
module tb_smbus_ioexp_int_sched;
  import ioexp_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int IDXW    = 3;
  localparam int HOLD    = 3;

  logic iClk = 1'b0;
  logic nrst, iClk_1ms, iEnable, iTimeout_clr;
  logic oINT_N, oBusy, oTimeout_flag;
  int   vectors = 0;
  int   miscompares = 0;
  int   sb[$];

  smbus_ioexp_int_sched_if #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) bus ();

  smbus_ioexp_int_sched #(
    .NUM_REQ(NUM_REQ), .IDXW(IDXW), .HOLDOFF_MS(16'd3), .TIMEOUT_MS(16'd5)
  ) dut (
    .iClk(iClk), .nrst(nrst), .iClk_1ms(iClk_1ms), .iEnable(iEnable),
    .iTimeout_clr(iTimeout_clr), .bus(bus), .oINT_N(oINT_N), .oBusy(oBusy),
    .oTimeout_flag(oTimeout_flag)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic tick();
    iClk_1ms = 1'b1;
    cyc(1);
    iClk_1ms = 1'b0;
  endtask

  task automatic rd(input logic [NUM_REQ-1:0] p0, input logic [NUM_REQ-1:0] p1);
    bus.iP0_rd = p0;
    bus.iP1_rd = p1;
    cyc(1);
    bus.iP0_rd = '0;
    bus.iP1_rd = '0;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 8; i++) begin
      if (bus.oAck != '0) break;
      cyc(1);
    end
    check("ack_seen", 32'(bus.oAck != '0), 1);
  endtask

  // Called in DELAY: hold-off ticks, ack, then GAP back to IDLE
  task automatic hold_and_ack();
    for (int i = 0; i < HOLD; i++) begin
      check("int_held_low", oINT_N, 0);
      tick();
    end
    wait_ack();
    check("int_high_in_ack", oINT_N, 1);
    cyc(1);
    check("ack_single", bus.oAck, 0);
    check("int_high_in_gap", oINT_N, 1);
    tick();
    check("idle_after_gap", oBusy, 0);
  endtask

  // Called just after the DUT entered ASSERT for idx
  task automatic serve(input int idx);
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1) << idx;
    check("grant_idx", bus.oGrant_idx, idx);
    check("int_low", oINT_N, 0);
    sb.push_back(idx);
    rd(oh, '0);
    check("int_low_after_p0", oINT_N, 0);
    rd('0, oh);
    hold_and_ack();
  endtask

  always @(negedge iClk) begin
    if (bus.oAck != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", bus.oAck, 0);
      end else begin
        int e;
        e = sb.pop_front();
        check("ack_vec", bus.oAck, 1 << e);
        check("ack_grant", bus.oGrant_idx, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; iClk_1ms = 1'b0; iEnable = 1'b1; iTimeout_clr = 1'b0;
    bus.iReq = '0; bus.iP0_rd = '0; bus.iP1_rd = '0;
    cyc(2);
    nrst = 1'b1;
    cyc(1);
    check("rst_int_n", oINT_N, 1);
    check("rst_ack", bus.oAck, 0);
    check("rst_grant", bus.oGrant_idx, 0);
    check("rst_busy", oBusy, 0);
    check("rst_tmo", oTimeout_flag, 0);

    // single request on idx1, one-cycle latency
    bus.iReq = 4'b0010;
    check("int_latency", oINT_N, 1);
    cyc(1);
    serve(1);
    bus.iReq = '0;

    // round robin between idx0 and idx3 from pointer 0
    nrst = 1'b0;
    cyc(1);
    nrst = 1'b1;
    bus.iReq = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      serve((k % 2 == 0) ? 0 : 3);
    end
    bus.iReq = '0;

    // foreign reads ignored; simultaneous reads go straight to DELAY
    bus.iReq = 4'b0001;
    cyc(1);
    check("grant_idx0", bus.oGrant_idx, 0);
    rd(4'b0100, 4'b0100);
    repeat (3) tick();
    cyc(2);
    check("foreign_no_ack", bus.oAck, 0);
    check("foreign_int_low", oINT_N, 0);
    check("foreign_busy", oBusy, 1);
    sb.push_back(0);
    rd(4'b0001, 4'b0001);
    hold_and_ack();
    bus.iReq = '0;

    // timeout forces ack and sets the sticky flag
    bus.iReq = 4'b0100;
    cyc(1);
    check("grant_idx2", bus.oGrant_idx, 2);
    sb.push_back(2);
    for (int i = 0; i < 5; i++) begin
      check("tmo_int_low", oINT_N, 0);
      check("tmo_early", oTimeout_flag, 0);
      tick();
    end
    wait_ack();
    check("tmo_set", oTimeout_flag, 1);
    bus.iReq = '0;
    cyc(1);
    check("tmo_sticky", oTimeout_flag, 1);
    iTimeout_clr = 1'b1;
    cyc(1);
    iTimeout_clr = 1'b0;
    check("tmo_cleared", oTimeout_flag, 0);
    tick();

    // disable during DELAY abandons the grant; pointer stays at 3
    bus.iReq = 4'b0011;
    cyc(1);
    check("grant_wrap_idx0", bus.oGrant_idx, 0);
    rd(4'b0001, 4'b0001);
    tick();
    iEnable = 1'b0;
    cyc(1);
    check("dis_int_high", oINT_N, 1);
    check("dis_idle", oBusy, 0);
    cyc(2);
    check("dis_no_grant", oBusy, 0);
    iEnable = 1'b1;
    cyc(1);
    serve(0);

    // async reset mid-ASSERT, re-grant after release
    cyc(1);
    check("grant_idx1", bus.oGrant_idx, 1);
    nrst = 1'b0;
    #1;
    check("arst_int_n", oINT_N, 1);
    check("arst_grant", bus.oGrant_idx, 0);
    check("arst_busy", oBusy, 0);
    check("arst_ack", bus.oAck, 0);
    #1;
    nrst = 1'b1;
    cyc(1);
    check("regrant_idx", bus.oGrant_idx, 0);
    check("regrant_int", oINT_N, 0);

    // withdrawn request during ASSERT drops back to IDLE without ack
    bus.iReq = 4'b0010;
    cyc(1);
    check("wdraw_int_high", oINT_N, 1);
    check("wdraw_idle", oBusy, 0);
    cyc(1);
    check("wdraw_next_grant", bus.oGrant_idx, 1);
    iEnable = 1'b0;
    bus.iReq = '0;
    cyc(2);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
